instr_word_encoder: RTL

- Streaming RISC-V RV32 instruction encoder; the inverse of the decode/immediate-generation path.
- Accepts field-level instruction descriptions (type, opcode, registers, functs, immediate) and packs each into a 32-bit instruction word.
- Range-checks the immediate and tags each word with a sequential instruction-memory byte address.
- Used by the program loader and the self-test stimulus path to fill instruction memory.

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/imm_encoder.sv | 47 ++++
 rtl/instr_word_encoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 encoding types, opcodes and immediate range limits.
package riscv_pkg;

  typedef enum logic [2:0] {
    R_TYPE       = 3'd0,
    I_TYPE       = 3'd1,
    S_TYPE       = 3'd2,
    B_TYPE       = 3'd3,
    U_TYPE       = 3'd4,
    J_TYPE       = 3'd5,
    UNKNOWN_TYPE = 3'd6
  } instruction_type_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic imm_type_e type_to_imm(instruction_type_e t);
    case (t)
      I_TYPE:  return IMM_I;
      S_TYPE:  return IMM_S;
      B_TYPE:  return IMM_B;
      U_TYPE:  return IMM_U;
      J_TYPE:  return IMM_J;
      default: return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_encoder.sv
// Scatters an immediate into its instruction bit positions and flags
// values that the selected format cannot represent.
module imm_encoder
  import riscv_pkg::*;
(
  input  imm_type_e   imm_type,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_err
);

  logic signed [31:0] imm_s;
  assign imm_s = imm;

  // Per-format bit placement and representability check
  always_comb begin
    imm_bits  = '0;
    range_err = 1'b0;
    case (imm_type)
      IMM_I: begin
        imm_bits  = {imm[11:0], 20'b0};
        range_err = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
      end
      IMM_S: begin
        imm_bits  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
      end
      IMM_B: begin
        imm_bits  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm[0];
      end
      IMM_U: begin
        imm_bits  = {imm[31:12], 12'b0};
        range_err = (imm[11:0] != 12'b0);
      end
      IMM_J: begin
        imm_bits  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm[0];
      end
      default: begin
        imm_bits  = '0;
        range_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Two-stage streaming RV32 instruction encoder with address tagging and
// NOP substitution on encode errors.
module instr_word_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_type,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  logic        s1_valid;
  logic [2:0]  s1_type;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;

  logic [ADDR_W-1:0] addr_cnt;
  logic              s2_adv;
  imm_type_e         imm_type;
  logic [31:0]       imm_bits;
  logic              range_err;
  logic              type_err;
  logic              enc_err;
  logic [31:0]       enc_word;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !clr && (!s1_valid || s2_adv);
  assign imm_type = type_to_imm(instruction_type_e'(s1_type));

  imm_encoder u_imm_encoder (
    .imm_type  (imm_type),
    .imm       (s1_imm),
    .imm_bits  (imm_bits),
    .range_err (range_err)
  );

  // Stage 1: capture the request fields on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_type   <= '0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_type   <= in_type;
        s1_opcode <= in_opcode;
        s1_rd     <= in_rd;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_funct3 <= in_funct3;
        s1_funct7 <= in_funct7;
        s1_imm    <= in_imm;
      end
    end
  end

  // Merge register/funct fields with the scattered immediate
  always_comb begin
    type_err = 1'b0;
    enc_word = '0;
    case (s1_type)
      R_TYPE: enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      I_TYPE: enc_word = {12'b0, s1_rs1, s1_funct3, s1_rd, s1_opcode} | imm_bits;
      S_TYPE,
      B_TYPE: enc_word = {7'b0, s1_rs2, s1_rs1, s1_funct3, 5'b0, s1_opcode} | imm_bits;
      U_TYPE,
      J_TYPE: enc_word = {20'b0, s1_rd, s1_opcode} | imm_bits;
      default: type_err = 1'b1;
    endcase
    enc_err = type_err || range_err;
  end

  // Stage 2: output word, address tag, error flag and saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE_A;
      out_err   <= 1'b0;
      err_count <= '0;
      addr_cnt  <= BASE_A;
    end else if (clr) begin
      out_valid <= 1'b0;
      addr_cnt  <= BASE_A;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= enc_err ? NOP_INSTR : enc_word;
        out_addr  <= addr_cnt;
        out_err   <= enc_err;
        addr_cnt  <= addr_cnt + ADDR_W'(4);
        if (enc_err && (err_count != '1)) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule
